// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the jtkiwi shared-memory arbiter: FSM encoding,
// default geometry and the round-robin pointer helper.
package jtkiwi_pkg;

    localparam int DEF_AW  = 13;
    localparam int DEF_DW  = 8;
    localparam int DEF_NCH = 2;
    // Grant index width; covers the full 2..4 channel range
    localparam int GW      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Channel that starts the search once channel g has been served
    function automatic logic [GW-1:0] next_start(input logic [GW-1:0] g, input int n);
        int t;
        t = (int'(g) + 1) % n;
        return GW'(t);
    endfunction

endpackage

// File: rtl/jtkiwi_shmem_arb.sv
// Grant picker for the shared RAM: fixed priority or round-robin search
// over the eligible channels, with the round-robin start pointer register.
module jtkiwi_shmem_arb
    import jtkiwi_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int RR  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] eligible,
    input  logic           advance,
    input  logic [GW-1:0]  last,
    output logic [GW-1:0]  win,
    output logic           any
);

    logic [GW-1:0] ptr;
    logic [GW-1:0] base;

    assign base = (RR != 0) ? ptr : '0;

    // Pick the first eligible channel walking upward from the start index
    always_comb begin
        int idx;
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(base) + k) % NCH;
            if (!any && eligible[idx]) begin
                any = 1'b1;
                win = GW'(idx);
            end
        end
    end

    // Move the search start past the channel that just finished
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= next_start(last, NCH);
        end
    end

endmodule

// File: rtl/jtkiwi_shmem.sv
// Shared single-port RAM for several CPU-side requesters. Each access takes
// IDLE -> ACCESS -> DONE; busy holds the requester until its access finishes.
module jtkiwi_shmem
    import jtkiwi_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int NCH = DEF_NCH,
    parameter int RR  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] din,
    output logic [NCH*DW-1:0] dout,
    output logic [NCH-1:0]    busy,
    output logic [7:0]        st_dout
);

    state_t            state;
    state_t            next_state;
    logic [GW-1:0]     gnt;
    logic [GW-1:0]     win;
    logic              any;
    logic              is_write;
    logic              req_ok;
    logic [NCH-1:0]    served;
    logic [NCH-1:0]    eligible;
    logic [NCH*DW-1:0] dout_r;
    logic [AW-1:0]     addr_sel;
    logic [DW-1:0]     din_sel;
    logic [DW-1:0]     ram_q;
    logic [DW-1:0]     mem [0:(1<<AW)-1];
    logic              take;
    logic              ram_we;
    logic              latch_rd;
    logic              finish;

    assign eligible = req & ~served;
    assign busy     = req & ~served;
    assign take     = (state == ST_IDLE) && cen && any;
    assign addr_sel = addr[int'(gnt)*AW +: AW];
    assign din_sel  = din[int'(gnt)*DW +: DW];
    assign dout     = dout_r;

    jtkiwi_shmem_arb #(
        .NCH (NCH),
        .RR  (RR)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .advance  (state == ST_DONE),
        .last     (gnt),
        .win      (win),
        .any      (any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next state: grant only on an enabled edge, then two fixed steps
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (take) next_state = ST_ACCESS;
            ST_ACCESS: next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Output decode: RAM strobe, read capture, completion and debug status
    always_comb begin
        ram_we   = rst_n && (state == ST_ACCESS) && is_write;
        finish   = (state == ST_DONE) && req_ok;
        latch_rd = finish && !is_write && req[gnt];
        st_dout  = {state, 2'b00, 2'b00, gnt};
    end

    // Grant bookkeeping, served flags and per-channel read latches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt      <= '0;
            is_write <= 1'b0;
            req_ok   <= 1'b0;
            served   <= '0;
            dout_r   <= '0;
        end else begin
            if (take) begin
                gnt      <= win;
                is_write <= we[win];
            end
            if (state == ST_ACCESS) begin
                req_ok <= req[gnt];
            end
            for (int i = 0; i < NCH; i++) begin
                served[i] <= req[i] & (served[i] | (finish && (int'(gnt) == i)));
            end
            if (latch_rd) begin
                dout_r[int'(gnt)*DW +: DW] <= ram_q;
            end
        end
    end

    // Single-port RAM; contents survive reset, only the write strobe is gated
    always_ff @(posedge clk) begin
        if (ram_we) mem[addr_sel] <= din_sel;
        ram_q <= mem[addr_sel];
    end

endmodule

// File: tb/tb_jtkiwi_shmem.sv
// Directed bench for jtkiwi_shmem: a vector table of single accesses plus
// hand-written collision, held-request, abort, reset and fairness sequences.
module tb_jtkiwi_shmem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;

    logic [1:0]  a_req, a_we, a_busy;
    logic [25:0] a_addr;
    logic [15:0] a_din, a_dout;
    logic [7:0]  a_st;

    logic [3:0]  f_req;
    logic [3:0]  b_busy, c_busy;
    logic [31:0] b_dout, c_dout;
    logic [7:0]  b_st, c_st;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         ch;
        logic       w;
        logic [12:0] ad;
        logic [7:0] d;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    jtkiwi_shmem #(.AW(13), .DW(8), .NCH(2), .RR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cen(cen), .req(a_req), .we(a_we),
        .addr(a_addr), .din(a_din), .dout(a_dout), .busy(a_busy), .st_dout(a_st)
    );

    jtkiwi_shmem #(.AW(13), .DW(8), .NCH(4), .RR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .cen(cen), .req(f_req), .we(4'b0000),
        .addr(52'd0), .din(32'd0), .dout(b_dout), .busy(b_busy), .st_dout(b_st)
    );

    jtkiwi_shmem #(.AW(13), .DW(8), .NCH(4), .RR(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .cen(cen), .req(f_req), .we(4'b0000),
        .addr(52'd0), .din(32'd0), .dout(c_dout), .busy(c_busy), .st_dout(c_st)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete access on dut_a; returns ticks until busy fell (bounded)
    task automatic apply_stimulus(input int ch, input logic w, input logic [12:0] ad,
                                  input logic [7:0] d, output int lat);
        a_we[ch] = w;
        a_addr[ch*13 +: 13] = ad;
        a_din[ch*8 +: 8] = d;
        a_req[ch] = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (a_busy[ch] && lat < 10);
        a_req[ch] = 1'b0;
        a_we[ch] = 1'b0;
        tick();
    endtask

    initial begin
        int lat, f0, f1, acc, bad;
        logic [1:0] exp_b[5];
        logic [1:0] exp_c[5];

        vecs[0] = '{0, 1'b1, 13'h0123, 8'hA5, 8'h00};
        vecs[1] = '{0, 1'b0, 13'h0123, 8'h00, 8'hA5};
        vecs[2] = '{1, 1'b1, 13'h1FFF, 8'h3C, 8'h00};
        vecs[3] = '{1, 1'b0, 13'h1FFF, 8'h00, 8'h3C};
        vecs[4] = '{0, 1'b0, 13'h1FFF, 8'h00, 8'h3C};
        vecs[5] = '{1, 1'b0, 13'h0123, 8'h00, 8'hA5};
        vecs[6] = '{0, 1'b1, 13'h0000, 8'hFF, 8'h3C};
        vecs[7] = '{0, 1'b0, 13'h0000, 8'h00, 8'hFF};
        vecs[8] = '{1, 1'b0, 13'h0000, 8'h00, 8'hFF};
        exp_b = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

        rst_n = 1'b0; cen = 1'b1;
        a_req = '0; a_we = '0; a_addr = '0; a_din = '0; f_req = '0;
        tick(); tick();

        // While in reset, busy follows req directly
        for (int i = 0; i < 4; i++) begin
            a_req = 2'(i);
            #1;
            check_output("busy_in_reset", 32'(a_busy), 32'(i));
        end
        a_req = '0;
        tick();
        check_output("reset_st", 32'(a_st), 32'h00);
        check_output("reset_dout", 32'(a_dout), 32'h0000);
        rst_n = 1'b1;
        tick();

        // Table of single accesses
        for (int v = 0; v < 9; v++) begin
            apply_stimulus(vecs[v].ch, vecs[v].w, vecs[v].ad, vecs[v].d, lat);
            check_output($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
            check_output($sformatf("vec%0d_dout", v), 32'(a_dout[vecs[v].ch*8 +: 8]),
                         32'(vecs[v].exp_dout));
        end

        // Collision: both channels write at the same edge
        a_we = 2'b11;
        a_addr = {13'h0011, 13'h0010};
        a_din = {8'h22, 8'h11};
        a_req = 2'b11;
        f0 = 0; f1 = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 1) check_output("collide_first_grant", 32'(a_st), 32'h40);
            if (f0 == 0 && !a_busy[0]) f0 = t;
            if (f1 == 0 && !a_busy[1]) f1 = t;
        end
        check_output("collide_busy0_fall", 32'(f0), 32'd3);
        check_output("collide_busy1_fall", 32'(f1), 32'd6);
        a_req = '0; a_we = '0;
        tick();
        apply_stimulus(0, 1'b0, 13'h0010, 8'h00, lat);
        check_output("collide_rd0", 32'(a_dout[7:0]), 32'h11);
        apply_stimulus(1, 1'b0, 13'h0011, 8'h00, lat);
        check_output("collide_rd1", 32'(a_dout[15:8]), 32'h22);

        // Held request after completion is not re-served
        a_addr[25:13] = 13'h0010;
        a_req[1] = 1'b1;
        acc = 0; bad = 0;
        for (int t = 1; t <= 13; t++) begin
            tick();
            if (a_st[7:6] == 2'd1) acc++;
            if (t > 3 && a_busy[1]) bad++;
        end
        check_output("held_accesses", 32'(acc), 32'd1);
        check_output("held_busy_high_ticks", 32'(bad), 32'd0);
        check_output("held_dout1", 32'(a_dout[15:8]), 32'h11);
        a_req = '0;
        tick();

        // Abort read: request dropped while in ACCESS
        a_addr[12:0] = 13'h1FFF;
        a_req[0] = 1'b1;
        tick();
        check_output("abort_rd_grant", 32'(a_st), 32'h40);
        a_req[0] = 1'b0;
        tick(); tick();
        check_output("abort_rd_dout0", 32'(a_dout[7:0]), 32'h11);
        check_output("abort_rd_busy", 32'(a_busy), 32'h0);

        // Abort write: request dropped while in ACCESS still commits
        a_addr[12:0] = 13'h0020;
        a_din[7:0] = 8'h77;
        a_we[0] = 1'b1;
        a_req[0] = 1'b1;
        tick();
        a_req[0] = 1'b0;
        tick(); tick();
        a_we[0] = 1'b0;
        apply_stimulus(0, 1'b0, 13'h0020, 8'h00, lat);
        check_output("abort_wr_readback", 32'(a_dout[7:0]), 32'h77);

        // Reset on the write edge suppresses the write
        apply_stimulus(0, 1'b1, 13'h0030, 8'h44, lat);
        a_addr[12:0] = 13'h0030;
        a_din[7:0] = 8'hEE;
        a_we[0] = 1'b1;
        a_req[0] = 1'b1;
        tick();
        check_output("rst_access_grant", 32'(a_st), 32'h40);
        rst_n = 1'b0;
        tick();
        check_output("rst_access_st", 32'(a_st), 32'h00);
        check_output("rst_access_busy", 32'(a_busy), 32'(a_req));
        check_output("rst_access_busy_val", 32'(a_busy), 32'h1);
        a_req = '0; a_we = '0;
        tick();
        rst_n = 1'b1;
        tick();
        apply_stimulus(0, 1'b0, 13'h0030, 8'h00, lat);
        check_output("rst_access_word", 32'(a_dout[7:0]), 32'h44);

        // Fairness: round-robin vs fixed priority, served cleared between rounds
        for (int r = 0; r < 5; r++) begin
            f_req = 4'hF;
            tick();
            check_output($sformatf("rr_state_r%0d", r), 32'(b_st[7:6]), 32'd1);
            check_output($sformatf("rr_gnt_r%0d", r), 32'(b_st[1:0]), 32'(exp_b[r]));
            check_output($sformatf("fixed_gnt_r%0d", r), 32'(c_st[1:0]), 32'(exp_c[r]));
            tick(); tick();
            f_req = 4'h0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
